// File: rtl/cadd_pkg.sv
// Shared state type and width helper for the iterative compressor adder.
package cadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cadd_state_e;

  // Iteration counter must hold values 0..width inclusive.
  function automatic int cadd_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/compressor_add_seq_compress_2to2.sv
// Single 2:2 bitwise compressor slice: per-bit sum and carry without propagation.
module compress_2to2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/compressor_add_seq.sv
// Multi-cycle adder that iterates one shared 2:2 compressor until the carry vector is empty.
// Optional carry-out port and register are enabled by defining CADD_SEQ_COUT_EN.
module compressor_add_seq
  import cadd_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = cadd_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_iters
`ifdef CADD_SEQ_COUT_EN
  ,
  output logic             out_cout
`endif
);

  cadd_state_e      state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] iters_q, iters_d;
  logic [WIDTH-1:0] cmpSum, cmpCarry;

  compress_2to2 #(
    .WIDTH(WIDTH)
  ) u_compress (
    .a(s_q),
    .b(c_q),
    .s(cmpSum),
    .c(cmpCarry)
  );

`ifdef CADD_SEQ_COUT_EN
  logic cout_q, cout_d;
`endif

  // Carries leaving the MSB are dropped from c_d so the sum wraps mod 2^WIDTH.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    iters_d = iters_q;
`ifdef CADD_SEQ_COUT_EN
    cout_d  = cout_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          s_d     = in_a;
          c_d     = in_b;
          iters_d = '0;
`ifdef CADD_SEQ_COUT_EN
          cout_d  = 1'b0;
`endif
        end
      end
      BUSY: begin
        if (c_q != '0) begin
          s_d     = cmpSum;
          c_d     = {cmpCarry[WIDTH-2:0], 1'b0};
          iters_d = iters_q + CNT_W'(1);
`ifdef CADD_SEQ_COUT_EN
          cout_d  = cout_q | cmpCarry[WIDTH-1];
`endif
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      iters_q <= iters_d;
    end
  end

`ifdef CADD_SEQ_COUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign out_cout = cout_q;
`endif

  // Ready is masked by rst_n so it reads low for the whole reset window.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = s_q;
  assign out_iters = iters_q;

endmodule

// File: tb/tb_compressor_add_seq.sv
// Self-checking bench for compressor_add_seq: directed vectors, corner sequences and random pairs.
module tb_compressor_add_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_iters;
  logic             outCout;

  int testsRun = 0;
  int failures = 0;

  compressor_add_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_iters(out_iters)
`ifdef CADD_SEQ_COUT_EN
    ,
    .out_cout (outCout)
`endif
  );

`ifndef CADD_SEQ_COUT_EN
  assign outCout = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck DUT still produces a verdict.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expSum;
    int          expIters;
    logic        expCout;
    int          expLat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: true sum from wide arithmetic; iteration count from the
  // "xor for sum, and-then-double for carry, repeat until carry is zero" rule.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] sum, output int n, output logic cout);
    longint unsigned full, s, c, t;
    full = longint'(a) + longint'(b);
    sum  = full[31:0];
    cout = full[32];
    s = longint'(a);
    c = longint'(b);
    n = 0;
    while (c != 0 && n < 64) begin
      t = s & c;
      s = s ^ c;
      c = (t * 2) % 64'h1_0000_0000;
      n++;
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit preReady,
                               input int holdCycles, output logic [31:0] sum,
                               output logic [CNT_W-1:0] iters, output logic cout,
                               output int lat, output bit ok);
    int guard;
    ok    = 1'b1;
    guard = 0;
    sum   = '0;
    iters = '0;
    cout  = 1'b0;
    lat   = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      ok = 1'b0;
      return;
    end
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = preReady;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < WIDTH + 20) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      ok        = 1'b0;
      return;
    end
    sum   = out_sum;
    iters = out_iters;
    cout  = outCout;
    if (!preReady) begin
      repeat (holdCycles) tick();
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0]      sum, expSum, ra, rb;
    logic [CNT_W-1:0] iters;
    logic             cout, expCout;
    int               lat, expN, guard;
    bit               ok;

    vecs[0] = '{a: 32'd13,         b: 32'd8,          expSum: 32'd21,  expIters: 2,  expCout: 1'b0, expLat: 4};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          expSum: 32'd0,   expIters: 32, expCout: 1'b1, expLat: 34};
    vecs[2] = '{a: 32'd5,          b: 32'd0,          expSum: 32'd5,   expIters: 0,  expCout: 1'b0, expLat: 2};
    vecs[3] = '{a: 32'd0,          b: 32'd0,          expSum: 32'd0,   expIters: 0,  expCout: 1'b0, expLat: 2};
    vecs[4] = '{a: 32'd100,        b: 32'd27,         expSum: 32'd127, expIters: 1,  expCout: 1'b0, expLat: 3};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  expSum: 32'd0,   expIters: 1,  expCout: 1'b1, expLat: 3};
    vecs[6] = '{a: 32'd3,          b: 32'd4,          expSum: 32'd7,   expIters: 1,  expCout: 1'b0, expLat: 3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_sum", 64'(out_sum), 64'd0);
    checkOutput("reset_out_iters", 64'(out_iters), 64'd0);
    checkOutput("reset_out_cout", 64'(outCout), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 0, sum, iters, cout, lat, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].expSum));
        checkOutput($sformatf("vec%0d_iters", i), 64'(iters), 64'(vecs[i].expIters));
        checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
`ifdef CADD_SEQ_COUT_EN
        checkOutput($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].expCout));
`endif
      end
    end

    // Back-pressure: result must hold while out_ready stays low, stray in_valid ignored.
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    in_a = 32'd100; in_b = 32'd27; in_valid = 1'b1;
    tick();
    in_a = 32'h55; in_b = 32'h11;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    checkOutput("bp_reached_done", 64'(out_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_a     = 32'(k * 7);
      in_b     = 32'(k + 1);
      checkOutput($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_sum_%0d", k), 64'(out_sum), 64'd127);
      checkOutput($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
    checkOutput("bp_valid_after", 64'(out_valid), 64'd0);
    tick();
    checkOutput("bp_no_phantom_op", 64'(out_valid), 64'd0);
    checkOutput("bp_still_idle", 64'(in_ready), 64'd1);

    // Reset mid-BUSY: everything returns to reset values asynchronously.
    in_a = 32'hFFFF_0000; in_b = 32'h0001_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_sum", 64'(out_sum), 64'd0);
    checkOutput("rst_mid_iters", 64'(out_iters), 64'd0);
    checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_mid_cout", 64'(outCout), 64'd0);
    tick();
    tick();
    checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_ready", 64'(in_ready), 64'd1);
    applyStimulus(32'd3, 32'd4, 1'b1, 0, sum, iters, cout, lat, ok);
    if (ok) begin
      checkOutput("post_rst_sum", 64'(sum), 64'd7);
      checkOutput("post_rst_iters", 64'(iters), 64'd1);
    end

    // Random pairs against the reference model, with random consumer stalls.
    for (int r = 0; r < 1000; r++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      refModel(ra, rb, expSum, expN, expCout);
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    sum, iters, cout, lat, ok);
      if (!ok) break;
      checkOutput($sformatf("rnd%0d_sum a=%0h b=%0h", r, ra, rb), 64'(sum), 64'(expSum));
      checkOutput($sformatf("rnd%0d_iters", r), 64'(iters), 64'(expN));
      checkOutput($sformatf("rnd%0d_iters_bound", r), 64'(iters <= 6'd32), 64'd1);
      checkOutput($sformatf("rnd%0d_latency", r), 64'(lat), 64'(expN + 2));
`ifdef CADD_SEQ_COUT_EN
      checkOutput($sformatf("rnd%0d_cout", r), 64'(cout), 64'(expCout));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
